uart_tx_ctrl: RTL and testbench

- Transmit-side controller that serialises a wide result word into consecutive bytes for the byte-level UART core.
- Latches `result` on a `trigger` pulse and drives the core's `tx_start` / `tx_data` / `tx_busy` handshake, MSB byte first.
- Raises `done` when the last byte has been accepted.
- Sits between the operation/result logic and the `uart_basic` transmitter; it is the return path for operands received by the RX controller.

---
 rtl/uart_tx_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//
// Serialises a WIDTH-bit result word into consecutive bytes for a byte-level
// UART transmitter, most significant byte first. A one-cycle trigger in IDLE
// latches the word; each byte is launched with a one-cycle tx_start strobe and
// the controller then follows the core's tx_busy flag (rise, then fall) before
// launching the next byte. A one-cycle done pulse closes the frame.
//
// Optional feature (build macro UART_TX_CTRL_CHECKSUM_EN):
//   When defined, every payload byte is XORed into an 8-bit checksum as it is
//   launched, and the checksum is sent as one extra trailing byte
//   (frame length NBYTES+1). When undefined, no checksum logic exists and the
//   frame length is NBYTES.
//
// Parameters:
//   WIDTH     result width in bits, multiple of 8, 8..64
//
// Ports:
//   clock     in   system clock
//   resetn    in   asynchronous active-low reset
//   trigger   in   one-cycle request to send result (honoured only in IDLE)
//   result    in   word to transmit, sampled when a trigger is accepted
//   tx_busy   in   UART core busy flag
//   tx_start  out  one-cycle byte launch strobe to the UART core
//   tx_data   out  byte presented to the UART core (0 in IDLE)
//   busy      out  high whenever the FSM is not in IDLE
//   done      out  one-cycle pulse when the frame is complete
//   overrun   out  sticky: a trigger arrived while not in IDLE
//   stateID   out  current state code for LED debug
//
// state   | code | meaning
// --------+------+-----------------------------------------------------------
// IDLE    |  0   | waiting for trigger, outputs quiet
// START   |  1   | tx_start high for one cycle, tx_data holds current byte
// WAIT_HI |  2   | waiting for the core to raise tx_busy
// WAIT_LO |  3   | waiting for the core to drop tx_busy
// DONE    |  4   | done high for one cycle
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             trigger,
  input  logic [WIDTH-1:0] result,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [3:0]       stateID
);

  localparam int NBYTES = WIDTH / 8;
`ifdef UART_TX_CTRL_CHECKSUM_EN
  localparam int TOTAL = NBYTES + 1;
`else
  localparam int TOTAL = NBYTES;
`endif
  // Sized so the counter can reach NBYTES+1 without wrapping.
  localparam int CW = $clog2(NBYTES + 2);

  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
`ifdef UART_TX_CTRL_CHECKSUM_EN
  localparam logic [CW-1:0] NBYTES_C = CW'(NBYTES);
`endif

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_START   = 4'd1;
  localparam logic [3:0] S_WAIT_HI = 4'd2;
  localparam logic [3:0] S_WAIT_LO = 4'd3;
  localparam logic [3:0] S_DONE    = 4'd4;

  logic [3:0]       state_q,    state_d;
  logic [WIDTH-1:0] shift_q,    shift_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q,  tx_data_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             overrun_q,  overrun_d;
`ifdef UART_TX_CTRL_CHECKSUM_EN
  logic [7:0]       chk_q,      chk_d;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    // A trigger outside IDLE is dropped but remembered until reset.
    overrun_d = overrun_q | (trigger && (state_q != S_IDLE));
`ifdef UART_TX_CTRL_CHECKSUM_EN
    chk_d     = chk_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d   = S_START;
          shift_d   = result;
          cnt_d     = '0;
          // Loaded here so the byte is already on tx_data during START.
          tx_data_d = result[WIDTH-1 -: 8];
`ifdef UART_TX_CTRL_CHECKSUM_EN
          chk_d     = 8'h00;
`endif
        end
      end

      S_START: begin
        state_d = S_WAIT_HI;
`ifdef UART_TX_CTRL_CHECKSUM_EN
        // Fold in payload bytes only; the trailing byte is the checksum itself.
        if (cnt_q < NBYTES_C) begin
          chk_d = chk_q ^ tx_data_q;
        end
`endif
      end

      S_WAIT_HI: begin
        if (tx_busy) begin
          state_d = S_WAIT_LO;
          shift_d = shift_q << 8;
          cnt_d   = cnt_q + 1'b1;
        end
      end

      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (cnt_q < TOTAL_C) begin
            state_d = S_START;
`ifdef UART_TX_CTRL_CHECKSUM_EN
            if (cnt_q == NBYTES_C) begin
              tx_data_d = chk_q;
            end else begin
              tx_data_d = shift_q[WIDTH-1 -: 8];
            end
`else
            tx_data_d = shift_q[WIDTH-1 -: 8];
`endif
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    if (state_d == S_IDLE) begin
      tx_data_d = 8'h00;
    end
    tx_start_d = (state_d == S_START);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef UART_TX_CTRL_CHECKSUM_EN
      chk_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
`ifdef UART_TX_CTRL_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = overrun_q;
  assign stateID  = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for uart_tx_ctrl (WIDTH = 16).
// A behavioural UART core model answers each tx_start with a tx_busy pulse of
// programmable delay and length. Expected bytes are pushed to a queue when a
// frame is triggered and popped by a monitor on every tx_start.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

`ifdef UART_TX_CTRL_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic        clock;
  logic        resetn;
  logic        trigger;
  logic [15:0] result;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [3:0]  stateID;

  uart_tx_ctrl #(.WIDTH(16)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .trigger  (trigger),
    .result   (result),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun),
    .stateID  (stateID)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int cyc = 0;
  int start_cnt = 0;
  int done_cnt  = 0;
  int start_cyc = 0;
  int done_cyc  = 0;
  int fall_cyc  = 0;
  int core_delay = 0;
  int core_len   = 10;

  logic [7:0] exp_q[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of the frame contents: MSB byte first, optional checksum.
  task automatic push_frame(input logic [15:0] w);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
`ifdef UART_TX_CTRL_CHECKSUM_EN
    exp_q.push_back(w[15:8] ^ w[7:0]);
`endif
  endtask

  // Called at posedge+1; trigger is sampled at the next posedge.
  task automatic send(input logic [15:0] w);
    trigger = 1'b1;
    result  = w;
    push_frame(w);
    @(posedge clock); #1;
    trigger = 1'b0;
    result  = ~w;
  endtask

  task automatic wait_done(input int bound);
    int d = done_cnt;
    int i = 0;
    while (done_cnt == d && i < bound) begin
      @(posedge clock); #1;
      i++;
    end
    check("done_seen", done_cnt - d, 1);
  endtask

  task automatic wait_start(input int s, input int bound);
    int i = 0;
    while (start_cnt == s && i < bound) begin
      @(posedge clock); #1;
      i++;
    end
    check("start_seen", start_cnt - s, 1);
  endtask

  task automatic wait_state(input logic [3:0] st, input int bound);
    int i = 0;
    while (stateID != st && i < bound) begin
      @(posedge clock); #1;
      i++;
    end
    check("reach_state", stateID, st);
  endtask

  // Monitor / scoreboard: compare every launched byte and count done pulses.
  initial begin
    logic [7:0] eb;
    logic       valid;
    forever begin
      @(negedge clock);
      if (tx_start === 1'b1) begin
        start_cnt++;
        start_cyc = cyc;
        check("start_while_busy", tx_busy, 1'b0);
        valid = (exp_q.size() > 0);
        eb    = valid ? exp_q.pop_front() : 8'h00;
        check("tx_byte", {55'd0, 1'b1, tx_data}, valid ? {55'd0, 1'b1, eb} : 64'd0);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // UART core model: busy rises core_delay cycles into WAIT_HI, lasts core_len.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_start === 1'b1) begin
        @(posedge clock); #1;
        repeat (core_delay) begin
          @(posedge clock); #1;
        end
        tx_busy = 1'b1;
        repeat (core_len) begin
          @(posedge clock); #1;
        end
        tx_busy  = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  initial begin
    int s0;
    int d0;
    int s;
    int first3;
    int bad;
    int sec;

    resetn  = 1'b1;
    trigger = 1'b0;
    result  = 16'h0000;
    #1 resetn = 1'b0;
    #1;
    check("reset_outputs", {tx_start, tx_data, busy, done, overrun, stateID}, 16'h0000);
    repeat (3) @(posedge clock);
    #3 resetn = 1'b1;
    @(posedge clock); #1;

    // Basic frame with launch latency check.
    s0 = start_cnt;
    d0 = done_cnt;
    trigger = 1'b1;
    result  = 16'hA55A;
    push_frame(16'hA55A);
    @(negedge clock);
    check("pre_launch_idle", {tx_start, busy}, 2'b00);
    @(posedge clock); #1;
    trigger = 1'b0;
    result  = 16'hFFFF;
    @(negedge clock);
    check("launch_latency", {tx_start, busy, stateID}, {1'b1, 1'b1, 4'd1});
    wait_done(200);
    check("basic_starts", start_cnt - s0, NB);
    check("basic_dones", done_cnt - d0, 1);
    check("done_after_busy_fall", done_cyc - fall_cyc, 1);
    check("basic_overrun", overrun, 1'b0);
    check("idle_outputs", {busy, tx_data}, 9'h000);

    // 1234 then back-to-back 00FF in the first IDLE cycle after done.
    s0 = start_cnt;
    send(16'h1234);
    wait_done(200);
    send(16'h00FF);
    wait_done(200);
    check("b2b_starts", start_cnt - s0, 2 * NB);
    check("b2b_overrun", overrun, 1'b0);
    check("b2b_queue_empty", exp_q.size(), 0);

    // Stretched busy: rises 5 cycles after tx_start, high for 200 cycles.
    core_delay = 4;
    core_len   = 200;
    s0 = start_cnt;
    send(16'h3CC3);
    wait_start(s0, 20);
    s = start_cyc;
    first3 = -1;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (tx_start === 1'b1) break;
      if (stateID == 4'd3 && first3 < 0) first3 = cyc;
      if (stateID != 4'd2 && stateID != 4'd3) bad++;
      if (stateID == 4'd2 && first3 >= 0) bad++;
    end
    sec = cyc;
    check("stretch_state_seq", bad, 0);
    check("stretch_wait_lo_entry", first3 - s, 6);
    check("stretch_second_start", tx_start, 1'b1);
    check("stretch_gap", sec - fall_cyc, 1);
    @(posedge clock); #1;
    wait_done(600);
    core_delay = 0;
    core_len   = 10;
    check("stretch_queue_empty", exp_q.size(), 0);

    // Overrun: second trigger during WAIT_LO is dropped.
    s0 = start_cnt;
    send(16'hBEEF);
    wait_state(4'd3, 50);
    trigger = 1'b1;
    result  = 16'h0000;
    @(posedge clock); #1;
    trigger = 1'b0;
    check("overrun_set", overrun, 1'b1);
    wait_done(200);
    check("overrun_starts", start_cnt - s0, NB);
    repeat (20) @(posedge clock);
    #1;
    check("no_second_frame", start_cnt - s0, NB);
    check("overrun_sticky", overrun, 1'b1);
    check("overrun_queue_empty", exp_q.size(), 0);

    // Reset in WAIT_LO of byte 0.
    send(16'h6996);
    wait_state(4'd3, 50);
    #2 resetn = 1'b0;
    #1;
    check("async_reset", {tx_start, tx_data, busy, done, overrun, stateID}, 16'h0000);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #3 resetn = 1'b1;
    s0 = start_cnt;
    repeat (30) @(posedge clock);
    #1;
    check("no_start_after_reset", start_cnt - s0, 0);
    check("idle_after_reset", stateID, 4'd0);

    // Recovery frame after reset.
    send(16'hC33C);
    wait_done(200);
    check("recovery_starts", start_cnt - s0, NB);
    check("recovery_queue_empty", exp_q.size(), 0);
    check("recovery_overrun", overrun, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
